// File: rtl/eblade_buf_pkg.sv
// Shared types and default geometry for the line-based packet buffer.
package eblade_buf_pkg;

   localparam int unsigned LINE_PTR_W = 3;
   localparam int unsigned CHAR_PTR_W = 11;
   localparam int unsigned MIN_FRAME  = 60;
   localparam int unsigned MAX_FRAME  = 1522;
   localparam int unsigned STAT_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      COMMIT = 2'd2,
      DROP   = 2'd3
   } wr_state_t;

   // Saturating increment used by the frame statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
      return (val == {STAT_W{1'b1}}) ? val : val + STAT_W'(1);
   endfunction

endpackage

// File: rtl/wr_stats_counter.sv
// 16-bit saturating event counter for write-side frame statistics.
module wr_stats_counter
   import eblade_buf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [STAT_W-1:0] count
);

   logic [STAT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/write_logic_fsm.sv
// Write-side frame controller: streams RX bytes into the current buffer line and commits or rewinds it.
// Optional WRITE_LOGIC_STATS_EN adds saturating good/drop/error frame counters.
module write_logic_fsm #(
   parameter int unsigned LINE_PTR_W = eblade_buf_pkg::LINE_PTR_W,
   parameter int unsigned CHAR_PTR_W = eblade_buf_pkg::CHAR_PTR_W,
   parameter int unsigned MIN_FRAME  = eblade_buf_pkg::MIN_FRAME,
   parameter int unsigned MAX_FRAME  = eblade_buf_pkg::MAX_FRAME
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rx_valid,
   output logic                             rx_ready,
   input  logic [7:0]                       rx_data,
   input  logic                             rx_sof,
   input  logic                             rx_eof,
   input  logic                             rx_err,
   input  logic [LINE_PTR_W+CHAR_PTR_W-1:0] wr_ptr,
   input  logic [LINE_PTR_W-1:0]            rd_line_ptr,
   output logic                             wr_en,
   output logic [7:0]                       wr_data,
   output logic                             wr_char_incr,
   output logic                             wr_newline,
   output logic                             wr_restart_line,
   output logic                             len_valid,
   output logic [CHAR_PTR_W-1:0]            len
`ifdef WRITE_LOGIC_STATS_EN
   ,
   output logic [eblade_buf_pkg::STAT_W-1:0] stat_good,
   output logic [eblade_buf_pkg::STAT_W-1:0] stat_drop,
   output logic [eblade_buf_pkg::STAT_W-1:0] stat_err
`endif
);

   import eblade_buf_pkg::*;

   localparam int unsigned PTR_W = LINE_PTR_W + CHAR_PTR_W;
   localparam logic [CHAR_PTR_W-1:0] MIN_LEN = CHAR_PTR_W'(MIN_FRAME);
   localparam logic [CHAR_PTR_W-1:0] MAX_LEN = CHAR_PTR_W'(MAX_FRAME);

   wr_state_t             state_q, state_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  wr_en_q, wr_en_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  char_incr_q, char_incr_d;
   logic                  newline_q, newline_d;
   logic                  restart_q, restart_d;
   logic                  len_valid_q, len_valid_d;
   logic [CHAR_PTR_W-1:0] len_q, len_d;
   logic [CHAR_PTR_W-1:0] cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  inc_good, inc_drop, inc_err;
   logic                  accept;
   logic                  full;
   logic [LINE_PTR_W-1:0] wr_line, eff_line;
   logic [CHAR_PTR_W-1:0] wr_char, bytes_written;

   assign accept  = rx_valid && rx_ready_q;
   assign wr_line = wr_ptr[PTR_W-1:CHAR_PTR_W];
   assign wr_char = wr_ptr[CHAR_PTR_W-1:0];

   // The counters see our registered strobes one cycle late: fold in a pending newline / write.
   assign eff_line      = wr_line + LINE_PTR_W'(newline_q);
   assign full          = (eff_line + LINE_PTR_W'(1)) == rd_line_ptr;
   assign bytes_written = wr_char + CHAR_PTR_W'(wr_en_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      rx_ready_d  = 1'b1;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      char_incr_d = 1'b0;
      newline_d   = 1'b0;
      restart_d   = 1'b0;
      len_valid_d = 1'b0;
      len_d       = len_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      inc_good    = 1'b0;
      inc_drop    = 1'b0;
      inc_err     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept && rx_sof) begin
               if (full) begin
                  inc_drop = 1'b1;
                  if (!rx_eof) begin
                     state_d = DROP;
                  end
               end else begin
                  wr_en_d     = 1'b1;
                  char_incr_d = 1'b1;
                  wr_data_d   = rx_data;
                  cnt_d       = CHAR_PTR_W'(1);
                  if (rx_eof) begin
                     state_d    = COMMIT;
                     rx_ready_d = 1'b0;
                     err_d      = rx_err;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
         end

         WRITE: begin
            if (accept) begin
               if (rx_sof || (cnt_q == MAX_LEN)) begin
                  // Missing eof or oversize: rewind and swallow the rest.
                  restart_d = 1'b1;
                  inc_err   = 1'b1;
                  state_d   = rx_eof ? IDLE : DROP;
               end else begin
                  wr_en_d     = 1'b1;
                  char_incr_d = 1'b1;
                  wr_data_d   = rx_data;
                  cnt_d       = cnt_q + CHAR_PTR_W'(1);
                  if (rx_eof) begin
                     state_d    = COMMIT;
                     rx_ready_d = 1'b0;
                     err_d      = rx_err;
                  end
               end
            end
         end

         COMMIT: begin
            state_d = IDLE;
            if (!err_q && (bytes_written >= MIN_LEN)) begin
               newline_d   = 1'b1;
               len_valid_d = 1'b1;
               len_d       = bytes_written;
               inc_good    = 1'b1;
            end else begin
               restart_d = 1'b1;
               inc_err   = 1'b1;
            end
         end

         DROP: begin
            if (accept && rx_eof) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         char_incr_q <= 1'b0;
         newline_q   <= 1'b0;
         restart_q   <= 1'b0;
         len_valid_q <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         char_incr_q <= char_incr_d;
         newline_q   <= newline_d;
         restart_q   <= restart_d;
         len_valid_q <= len_valid_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

   assign rx_ready        = rx_ready_q;
   assign wr_en           = wr_en_q;
   assign wr_data         = wr_data_q;
   assign wr_char_incr    = char_incr_q;
   assign wr_newline      = newline_q;
   assign wr_restart_line = restart_q;
   assign len_valid       = len_valid_q;
   assign len             = len_q;

`ifdef WRITE_LOGIC_STATS_EN
   wr_stats_counter u_stat_good (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_good),
      .count (stat_good)
   );

   wr_stats_counter u_stat_drop (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_drop),
      .count (stat_drop)
   );

   wr_stats_counter u_stat_err (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_err),
      .count (stat_err)
   );
`else
   logic unused_stats;
   assign unused_stats = ^{inc_good, inc_drop, inc_err};
`endif

endmodule

// File: tb/tb_write_logic_fsm.sv
// Directed bench for write_logic_fsm with a behavioural model of write_logic_counters closing the wr_ptr loop.
module tb_write_logic_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  rx_data = '0;
   logic        rx_sof = 1'b0;
   logic        rx_eof = 1'b0;
   logic        rx_err = 1'b0;
   logic [13:0] wr_ptr;
   logic [2:0]  rd_line_ptr = '0;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        wr_char_incr;
   logic        wr_newline;
   logic        wr_restart_line;
   logic        len_valid;
   logic [10:0] len;
`ifdef WRITE_LOGIC_STATS_EN
   logic [15:0] stat_good, stat_drop, stat_err;
`endif

   always #5 clk = ~clk;

   write_logic_fsm dut (
      .clk             (clk),
      .rst             (rst),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .rx_sof          (rx_sof),
      .rx_eof          (rx_eof),
      .rx_err          (rx_err),
      .wr_ptr          (wr_ptr),
      .rd_line_ptr     (rd_line_ptr),
      .wr_en           (wr_en),
      .wr_data         (wr_data),
      .wr_char_incr    (wr_char_incr),
      .wr_newline      (wr_newline),
      .wr_restart_line (wr_restart_line),
      .len_valid       (len_valid),
      .len             (len)
`ifdef WRITE_LOGIC_STATS_EN
      ,
      .stat_good       (stat_good),
      .stat_drop       (stat_drop),
      .stat_err        (stat_err)
`endif
   );

   // Model of the downstream line/char counters.
   logic [2:0]  m_line;
   logic [10:0] m_char;
   assign wr_ptr = {m_line, m_char};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_line <= '0;
         m_char <= '0;
      end else if (wr_restart_line) begin
         m_char <= '0;
      end else if (wr_newline) begin
         m_line <= m_line + 3'd1;
         m_char <= '0;
      end else if (wr_char_incr) begin
         m_char <= m_char + 11'd1;
      end
   end

   // Event monitor; byte i of every frame carries data i, so data must match the char address.
   int cyc = 0, eof_cyc = 0, lat = 0;
   int n_wr = 0, n_bad = 0, n_nl = 0, n_rs = 0, n_lv = 0, n_viol = 0;
   logic [10:0] last_len = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en) begin
         n_wr <= n_wr + 1;
         if (wr_data != wr_ptr[7:0]) n_bad <= n_bad + 1;
      end
      if (wr_newline) begin
         n_nl <= n_nl + 1;
         lat  <= cyc - eof_cyc;
      end
      if (wr_restart_line) n_rs <= n_rs + 1;
      if (len_valid) begin
         n_lv     <= n_lv + 1;
         last_len <= len;
      end
      if (rx_valid && rx_ready && rx_eof) eof_cyc <= cyc;
      if ((wr_newline && wr_restart_line) ||
          ((wr_newline || wr_restart_line) && wr_char_incr) ||
          (wr_en != wr_char_incr) || (len_valid != wr_newline))
         n_viol <= n_viol + 1;
   end

   logic [24:0] outs;
   assign outs = {rx_ready, wr_en, wr_data, wr_char_incr, wr_newline, wr_restart_line, len_valid, len};

   int n_vec = 0, n_miss = 0;
   int s_wr, s_bad, s_nl, s_rs, s_lv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      s_wr  = n_wr;
      s_bad = n_bad;
      s_nl  = n_nl;
      s_rs  = n_rs;
      s_lv  = n_lv;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic err);
      int guard;
      guard    = 0;
      rx_valid = 1'b1;
      rx_data  = d;
      rx_sof   = sof;
      rx_eof   = eof;
      rx_err   = err;
      while (!rx_ready && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) check("rx_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic err, input logic with_eof, input int gap);
      for (int i = 0; i < n; i++) begin
         send_byte(8'(i), i == 0, with_eof && (i == n - 1), err && (i == n - 1));
      end
      repeat (gap) @(negedge clk);
   endtask

   // Applies one frame and checks the write/commit/rewind deltas against hand-computed values.
   task automatic frame_case(input string tag, input int n, input logic err, input int exp_wr,
                             input int exp_lv, input int exp_rs, input int exp_len, input int exp_line);
      snap();
      send_frame(n, err, 1'b1, 5);
      check({tag, "_wr"},      32'(n_wr - s_wr), 32'(exp_wr));
      check({tag, "_lenvld"},  32'(n_lv - s_lv), 32'(exp_lv));
      check({tag, "_restart"}, 32'(n_rs - s_rs), 32'(exp_rs));
      check({tag, "_line"},    32'(m_line), 32'(exp_line));
      check({tag, "_char"},    32'(m_char), 32'd0);
      check({tag, "_addr"},    32'(n_bad - s_bad), 32'd0);
      if (exp_lv != 0) check({tag, "_len"}, 32'(last_len), 32'(exp_len));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(rx_ready), 32'd1);

      frame_case("good64", 64, 1'b0, 64, 1, 0, 64, 1);
      check("good64_latency", 32'(lat), 32'd2);
      frame_case("err64",  64, 1'b1, 64, 0, 1, 0, 1);
      frame_case("runt40", 40, 1'b0, 40, 0, 1, 0, 1);
      frame_case("runt59", 59, 1'b0, 59, 0, 1, 0, 1);
      frame_case("one_b",   1, 1'b0,  1, 0, 1, 0, 1);
      frame_case("min60",  60, 1'b0, 60, 1, 0, 60, 2);

      // Frame missing its eof: the next sof rewinds and that frame is swallowed.
      snap();
      send_frame(20, 1'b0, 1'b0, 0);
      send_frame(64, 1'b0, 1'b1, 5);
      check("noeof_wr",      32'(n_wr - s_wr), 32'd20);
      check("noeof_restart", 32'(n_rs - s_rs), 32'd1);
      check("noeof_lenvld",  32'(n_lv - s_lv), 32'd0);
      check("noeof_line",    32'(m_line), 32'd2);

      frame_case("over1530", 1530, 1'b0, 1522, 0, 1, 0, 2);
      frame_case("after_over", 64, 1'b0, 64, 1, 0, 64, 3);

      // Back-to-back fill to line 7, then an immediate frame must see the buffer full.
      snap();
      for (int f = 0; f < 4; f++) send_frame(60, 1'b0, 1'b1, 0);
      send_frame(60, 1'b0, 1'b1, 5);
      check("fill_lenvld", 32'(n_lv - s_lv), 32'd4);
      check("fill_wr",     32'(n_wr - s_wr), 32'd240);
      check("fill_line",   32'(m_line), 32'd7);
      check("fill_nl",     32'(n_nl - s_nl), 32'd4);

      rd_line_ptr = 3'd1;
      frame_case("line7", 64, 1'b0, 64, 1, 0, 64, 0);
`ifdef WRITE_LOGIC_STATS_EN
      check("stat_good", 32'(stat_good), 32'd8);
      check("stat_drop", 32'(stat_drop), 32'd1);
      check("stat_err",  32'(stat_err),  32'd6);
`endif

      // Reset in the middle of a frame.
      rd_line_ptr = 3'd0;
      send_frame(30, 1'b0, 1'b0, 0);
      rst = 1'b1;
      #1;
      check("midrst_outs", 32'(outs), 32'd0);
      check("midrst_ptr",  32'(wr_ptr), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frame_case("post_rst", 64, 1'b0, 64, 1, 0, 64, 1);
`ifdef WRITE_LOGIC_STATS_EN
      check("stat_good_rst", 32'(stat_good), 32'd1);
      check("stat_err_rst",  32'(stat_err),  32'd0);
`endif
      check("strobe_rules", 32'(n_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
